// File: rtl/m107_sprite_line_render.sv
// Per-scanline sprite renderer: scans object RAM, fetches 4bpp tile rows over a toggle handshake
// and writes opaque, visible pixels to the line buffer. Optional macro: M107_SPRITE_LAYER_MASK_EN.
module m107_sprite_line_render #(
    parameter logic [24:0] SDR_BASE  = 25'h0800000,
    parameter int          H_VISIBLE = 320,
    parameter int          OBJ_COUNT = 512
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ce,
    input  logic        line_start,
    input  logic [8:0]  vline,
    input  logic        obj_busy,
`ifdef M107_SPRITE_LAYER_MASK_EN
    input  logic [7:0]  layer_mask,
`endif
    output logic [10:0] obj_rd_addr,
    input  logic [15:0] obj_rd_data,
    output logic [24:0] sdr_addr,
    output logic        sdr_req,
    input  logic        sdr_ack,
    input  logic [63:0] sdr_data,
    output logic        lb_we,
    output logic [9:0]  lb_addr,
    output logic [11:0] lb_data,
    output logic        busy,
    output logic        done
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_RD0,
        S_RD1,
        S_RD2,
        S_RD3,
        S_CHECK,
        S_FETCH,
        S_WAIT_SDR,
        S_DRAW,
        S_NEXT_COL,
        S_NEXT_OBJ,
        S_DONE
    } state_t;

    localparam logic [8:0]  LAST_IDX = 9'(OBJ_COUNT - 1);
    localparam logic [10:0] H_VIS    = 11'(H_VISIBLE);

    state_t      state_q, state_d;
    logic [8:0]  idx_q, idx_d;
    logic [8:0]  vline_q, vline_d;
    logic        skip_q, skip_d;
    logic        start_pend_q, start_pend_d;
    logic        abort_q, abort_d;
    logic [8:0]  y_q, y_d;
    logic [1:0]  hsel_q, hsel_d;
    logic [1:0]  wsel_q, wsel_d;
    logic [15:0] code_q, code_d;
    logic [6:0]  color_q, color_d;
    logic        prio_q, prio_d;
    logic        flipx_q, flipx_d;
    logic        flipy_q, flipy_d;
    logic [9:0]  x_q, x_d;
    logic [6:0]  r_q, r_d;
    logic [2:0]  col_q, col_d;
    logic [3:0]  pix_cnt_q, pix_cnt_d;
    logic [63:0] row_q, row_d;
    logic [10:0] obj_rd_addr_q, obj_rd_addr_d;
    logic [24:0] sdr_addr_q, sdr_addr_d;
    logic        sdr_req_q, sdr_req_d;
    logic        lb_we_q, lb_we_d;
    logic [9:0]  lb_addr_q, lb_addr_d;
    logic [11:0] lb_data_q, lb_data_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
`ifdef M107_SPRITE_LAYER_MASK_EN
    logic [2:0]  layer_q, layer_d;
`endif

    // Object decode and per-pixel datapath, all derived from captured object words
    logic [8:0]  ly;
    logic [7:0]  hpx;
    logic [6:0]  hpx_m1;
    logic [6:0]  row_sel;
    logic        masked;
    logic        hit;
    logic [2:0]  cols_m1;
    logic [2:0]  xc;
    logic [15:0] tile;
    logic [3:0]  src;
    logic [3:0]  cur_pix;
    logic [9:0]  px;
    logic        px_vis;
    logic        start_evt;
    logic        start_skip;

    assign ly      = vline_q - y_q;
    assign hpx     = 8'd16 << hsel_q;
    assign hpx_m1  = 7'(hpx - 8'd1);
    assign row_sel = flipy_q ? (hpx_m1 - ly[6:0]) : ly[6:0];
`ifdef M107_SPRITE_LAYER_MASK_EN
    assign masked  = layer_mask[layer_q];
`else
    assign masked  = 1'b0;
`endif
    assign hit     = (ly < {1'b0, hpx}) && !masked;
    assign cols_m1 = 3'((4'd1 << wsel_q) - 4'd1);
    assign xc      = flipx_q ? (cols_m1 - col_q) : col_q;
    assign tile    = code_q + {10'd0, col_q, 3'd0} + {13'd0, r_q[6:4]};
    assign src     = flipx_q ? ~pix_cnt_q : pix_cnt_q;
    assign cur_pix = row_q[{src, 2'b00} +: 4];
    assign px      = x_q + {3'd0, xc, 4'd0} + {6'd0, pix_cnt_q};
    assign px_vis  = {1'b0, px} < H_VIS;

    // A line_start seen while ce=0 is held until the next enabled cycle
    assign start_evt  = line_start | start_pend_q;
    assign start_skip = line_start ? obj_busy : skip_q;

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        abort_d       = abort_q;
        y_d           = y_q;
        hsel_d        = hsel_q;
        wsel_d        = wsel_q;
        code_d        = code_q;
        color_d       = color_q;
        prio_d        = prio_q;
        flipx_d       = flipx_q;
        flipy_d       = flipy_q;
        x_d           = x_q;
        r_d           = r_q;
        col_d         = col_q;
        pix_cnt_d     = pix_cnt_q;
        row_d         = row_q;
        obj_rd_addr_d = obj_rd_addr_q;
        sdr_addr_d    = sdr_addr_q;
        sdr_req_d     = sdr_req_q;
        lb_we_d       = 1'b0;
        lb_addr_d     = lb_addr_q;
        lb_data_d     = lb_data_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
`ifdef M107_SPRITE_LAYER_MASK_EN
        layer_d       = layer_q;
`endif
        vline_d       = line_start ? vline : vline_q;
        skip_d        = line_start ? obj_busy : skip_q;
        start_pend_d  = start_evt & ~ce;

        if (ce) begin
            if (start_evt) begin
                busy_d = 1'b1;
                idx_d  = '0;
                // A request already in flight must complete before its data can be dropped
                if (state_q == S_WAIT_SDR && sdr_req_q != sdr_ack) begin
                    abort_d = 1'b1;
                end else begin
                    abort_d = 1'b0;
                    state_d = start_skip ? S_DONE : S_RD0;
                end
            end else begin
                unique case (state_q)
                    S_IDLE: ;
                    S_RD0: state_d = S_RD1;
                    S_RD1: begin
                        y_d     = obj_rd_data[8:0];
                        hsel_d  = obj_rd_data[10:9];
                        wsel_d  = obj_rd_data[12:11];
`ifdef M107_SPRITE_LAYER_MASK_EN
                        layer_d = obj_rd_data[15:13];
`endif
                        state_d = S_RD2;
                    end
                    S_RD2: begin
                        code_d  = obj_rd_data;
                        state_d = S_RD3;
                    end
                    S_RD3: begin
                        color_d = obj_rd_data[6:0];
                        prio_d  = obj_rd_data[7];
                        flipx_d = obj_rd_data[8];
                        flipy_d = obj_rd_data[9];
                        state_d = S_CHECK;
                    end
                    S_CHECK: begin
                        x_d = obj_rd_data[9:0];
                        if (hit) begin
                            r_d     = row_sel;
                            col_d   = '0;
                            state_d = S_FETCH;
                        end else begin
                            state_d = S_NEXT_OBJ;
                        end
                    end
                    S_FETCH: begin
                        sdr_addr_d = SDR_BASE + {2'b00, tile, r_q[3:0], 3'b000};
                        sdr_req_d  = ~sdr_req_q;
                        state_d    = S_WAIT_SDR;
                    end
                    S_WAIT_SDR: begin
                        if (sdr_req_q == sdr_ack) begin
                            if (abort_q) begin
                                abort_d = 1'b0;
                                state_d = skip_q ? S_DONE : S_RD0;
                            end else begin
                                row_d     = sdr_data;
                                pix_cnt_d = '0;
                                state_d   = S_DRAW;
                            end
                        end
                    end
                    S_DRAW: begin
                        if (cur_pix != 4'd0 && px_vis) begin
                            lb_we_d   = 1'b1;
                            lb_addr_d = px;
                            lb_data_d = {prio_q, color_q, cur_pix};
                        end
                        pix_cnt_d = pix_cnt_q + 4'd1;
                        if (pix_cnt_q == 4'd15) begin
                            state_d = S_NEXT_COL;
                        end
                    end
                    S_NEXT_COL: begin
                        if (col_q == cols_m1) begin
                            state_d = S_NEXT_OBJ;
                        end else begin
                            col_d   = col_q + 3'd1;
                            state_d = S_FETCH;
                        end
                    end
                    S_NEXT_OBJ: begin
                        if (idx_q == LAST_IDX) begin
                            state_d = S_DONE;
                        end else begin
                            idx_d   = idx_q + 9'd1;
                            state_d = S_RD0;
                        end
                    end
                    S_DONE: begin
                        busy_d  = 1'b0;
                        state_d = S_IDLE;
                    end
                    default: state_d = S_IDLE;
                endcase
            end

            if (state_d == S_DONE && (state_q != S_DONE || start_evt)) begin
                done_d = 1'b1;
            end

            // Object RAM address follows the read state being entered
            unique case (state_d)
                S_RD0:   obj_rd_addr_d = {idx_d, 2'd0};
                S_RD1:   obj_rd_addr_d = {idx_d, 2'd1};
                S_RD2:   obj_rd_addr_d = {idx_d, 2'd2};
                S_RD3:   obj_rd_addr_d = {idx_d, 2'd3};
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            idx_q         <= '0;
            vline_q       <= '0;
            skip_q        <= 1'b0;
            start_pend_q  <= 1'b0;
            abort_q       <= 1'b0;
            y_q           <= '0;
            hsel_q        <= '0;
            wsel_q        <= '0;
            code_q        <= '0;
            color_q       <= '0;
            prio_q        <= 1'b0;
            flipx_q       <= 1'b0;
            flipy_q       <= 1'b0;
            x_q           <= '0;
            r_q           <= '0;
            col_q         <= '0;
            pix_cnt_q     <= '0;
            row_q         <= '0;
            obj_rd_addr_q <= '0;
            sdr_addr_q    <= '0;
            sdr_req_q     <= 1'b0;
            lb_we_q       <= 1'b0;
            lb_addr_q     <= '0;
            lb_data_q     <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
`ifdef M107_SPRITE_LAYER_MASK_EN
            layer_q       <= '0;
`endif
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            vline_q       <= vline_d;
            skip_q        <= skip_d;
            start_pend_q  <= start_pend_d;
            abort_q       <= abort_d;
            y_q           <= y_d;
            hsel_q        <= hsel_d;
            wsel_q        <= wsel_d;
            code_q        <= code_d;
            color_q       <= color_d;
            prio_q        <= prio_d;
            flipx_q       <= flipx_d;
            flipy_q       <= flipy_d;
            x_q           <= x_d;
            r_q           <= r_d;
            col_q         <= col_d;
            pix_cnt_q     <= pix_cnt_d;
            row_q         <= row_d;
            obj_rd_addr_q <= obj_rd_addr_d;
            sdr_addr_q    <= sdr_addr_d;
            sdr_req_q     <= sdr_req_d;
            lb_we_q       <= lb_we_d;
            lb_addr_q     <= lb_addr_d;
            lb_data_q     <= lb_data_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
`ifdef M107_SPRITE_LAYER_MASK_EN
            layer_q       <= layer_d;
`endif
        end
    end

    assign obj_rd_addr = obj_rd_addr_q;
    assign sdr_addr    = sdr_addr_q;
    assign sdr_req     = sdr_req_q;
    assign lb_we       = lb_we_q;
    assign lb_addr     = lb_addr_q;
    assign lb_data     = lb_data_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_m107_sprite_line_render.sv
// Bench for m107_sprite_line_render: object RAM + SDRAM responder models and a per-line
// scoreboard of expected fetch addresses and line-buffer writes computed from object words.
module tb_m107_sprite_line_render;

    localparam logic [24:0] SDR_BASE = 25'h0800000;

    logic        clk = 1'b0;
    logic        reset;
    logic        ce;
    logic        line_start;
    logic [8:0]  vline;
    logic        obj_busy;
    logic [10:0] obj_rd_addr;
    logic [15:0] obj_rd_data = 16'd0;
    logic [24:0] sdr_addr;
    logic        sdr_req;
    logic        sdr_ack;
    logic [63:0] sdr_data;
    logic        lb_we;
    logic [9:0]  lb_addr;
    logic [11:0] lb_data;
    logic        busy;
    logic        done;

    m107_sprite_line_render dut (
        .clk         (clk),
        .reset       (reset),
        .ce          (ce),
        .line_start  (line_start),
        .vline       (vline),
        .obj_busy    (obj_busy),
`ifdef M107_SPRITE_LAYER_MASK_EN
        .layer_mask  (8'h00),
`endif
        .obj_rd_addr (obj_rd_addr),
        .obj_rd_data (obj_rd_data),
        .sdr_addr    (sdr_addr),
        .sdr_req     (sdr_req),
        .sdr_ack     (sdr_ack),
        .sdr_data    (sdr_data),
        .lb_we       (lb_we),
        .lb_addr     (lb_addr),
        .lb_data     (lb_data),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    logic [15:0] oram [0:2047];
    always @(posedge clk) if (ce) obj_rd_data <= oram[obj_rd_addr];

    logic [21:0] exp_wr[$];
    logic [24:0] exp_fetch[$];
    int          vectors = 0;
    int          errors  = 0;
    int          wr_count, fetch_count, cyc, done_cyc, start_cyc;
    bit          done_seen, mon_en, ce_rand;
    logic [21:0] first_wr, last_wr;
    logic [24:0] first_fetch;

    function automatic logic [63:0] tile_row(input logic [24:0] a);
        return 64'hFEDCBA9876543210 ^ {16{a[14:11]}};
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
        vectors++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, got, req);
        end
    endtask

    task automatic clear_objs();
        for (int i = 0; i < 512; i++) begin
            oram[4*i]   = 16'd300;
            oram[4*i+1] = 16'd0;
            oram[4*i+2] = 16'd0;
            oram[4*i+3] = 16'd0;
        end
    endtask

    task automatic set_obj(input int idx, input int y, input int h, input int w, input int layer,
                           input int code, input int color, input int prio, input int fx,
                           input int fy, input int x);
        oram[4*idx]   = {3'(layer), 2'(w), 2'(h), 9'(y)};
        oram[4*idx+1] = 16'(code);
        oram[4*idx+2] = {6'd0, 1'(fy), 1'(fx), 1'(prio), 7'(color)};
        oram[4*idx+3] = {6'd0, 10'(x)};
    endtask

    // Reference model: walk the objects in order and list every fetch and visible opaque write
    task automatic prepare(input int vl, input bit bsy);
        exp_wr.delete();
        exp_fetch.delete();
        wr_count = 0; fetch_count = 0; done_seen = 1'b0;
        if (!bsy) begin
            for (int i = 0; i < 512; i++) begin
                int y, hp, cols, code, color, prio, fx, fy, x, ly, r;
                y     = int'(oram[4*i][8:0]);
                hp    = 16 << int'(oram[4*i][10:9]);
                cols  = 1 << int'(oram[4*i][12:11]);
                code  = int'(oram[4*i+1]);
                color = int'(oram[4*i+2][6:0]);
                prio  = int'(oram[4*i+2][7]);
                fx    = int'(oram[4*i+2][8]);
                fy    = int'(oram[4*i+2][9]);
                x     = int'(oram[4*i+3][9:0]);
                ly    = (vl - y + 512) % 512;
                if (ly >= hp) continue;
                r = fy ? hp - 1 - ly : ly;
                for (int c = 0; c < cols; c++) begin
                    int tile, addr, xc;
                    logic [63:0] data;
                    tile = (code + c * 8 + r / 16) % 65536;
                    addr = int'(SDR_BASE) + tile * 128 + (r % 16) * 8;
                    exp_fetch.push_back(25'(addr));
                    data = tile_row(25'(addr));
                    xc = fx ? cols - 1 - c : c;
                    for (int p = 0; p < 16; p++) begin
                        int src, pix, px;
                        src = fx ? 15 - p : p;
                        pix = int'((data >> (4 * src)) & 64'hF);
                        px  = (x + xc * 16 + p) % 1024;
                        if (pix != 0 && px < 320)
                            exp_wr.push_back({10'(px), 1'(prio), 7'(color), 4'(pix)});
                    end
                end
            end
        end
    endtask

    // Compare process: every write strobe and every request toggle is checked against the model
    initial begin
        logic [21:0] ew;
        logic [24:0] ef;
        logic        req_prev;
        cyc = 0;
        req_prev = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (mon_en) begin
                if (lb_we) begin
                    wr_count++;
                    if (wr_count == 1) first_wr = {lb_addr, lb_data};
                    last_wr = {lb_addr, lb_data};
                    vectors++;
                    if (exp_wr.size() == 0) begin
                        errors++;
                        $display("FAIL lb_write_extra: got x=%0d data=%h, required no write", lb_addr, lb_data);
                    end else begin
                        ew = exp_wr.pop_front();
                        if ({lb_addr, lb_data} !== ew) begin
                            errors++;
                            $display("FAIL lb_write: got x=%0d data=%h required x=%0d data=%h",
                                     lb_addr, lb_data, ew[21:12], ew[11:0]);
                        end
                    end
                end
                if (sdr_req !== req_prev) begin
                    fetch_count++;
                    if (fetch_count == 1) first_fetch = sdr_addr;
                    vectors++;
                    if (exp_fetch.size() == 0) begin
                        errors++;
                        $display("FAIL sdr_fetch_extra: got addr=%h, required no fetch", sdr_addr);
                    end else begin
                        ef = exp_fetch.pop_front();
                        if (sdr_addr !== ef) begin
                            errors++;
                            $display("FAIL sdr_fetch: got addr=%h required %h", sdr_addr, ef);
                        end
                    end
                end
                if (done && !done_seen) begin
                    done_seen = 1'b1;
                    done_cyc  = cyc;
                end
            end
            req_prev = sdr_req;
        end
    end

    // SDRAM responder: acknowledge three cycles after a request toggle
    initial begin
        int lat;
        lat = 0;
        sdr_ack = 1'b0;
        sdr_data = 64'd0;
        forever begin
            @(posedge clk); #1;
            if (sdr_req !== sdr_ack) begin
                lat++;
                if (lat >= 3) begin
                    sdr_data = tile_row(sdr_addr);
                    sdr_ack  = sdr_req;
                    lat      = 0;
                end
            end
        end
    end

    initial begin
        ce = 1'b1;
        forever begin
            @(posedge clk); #1;
            ce = ce_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
    end

    task automatic start_line(input int vl, input bit bsy);
        @(posedge clk); #1;
        vline = 9'(vl); obj_busy = bsy; line_start = 1'b1; start_cyc = cyc;
        @(posedge clk); #1;
        line_start = 1'b0; obj_busy = 1'b0;
    endtask

    task automatic wait_done(input string name, input int vl);
        int n;
        n = 0;
        while (!done_seen && n < 30000) begin
            @(posedge clk); #1;
            n++;
        end
        check({name, "_done"}, 64'(done_seen), 64'd1);
        check({name, "_wr_left"}, 64'(exp_wr.size()), 64'd0);
        check({name, "_fetch_left"}, 64'(exp_fetch.size()), 64'd0);
        $display("line %s: vline=%0d writes=%0d fetches=%0d", name, vl, wr_count, fetch_count);
    endtask

    initial begin
        int n;
        reset = 1'b1; line_start = 1'b0; vline = '0; obj_busy = 1'b0;
        ce_rand = 1'b0; mon_en = 1'b0;
        clear_objs();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", 64'({busy, done, lb_we, sdr_req, obj_rd_addr, lb_addr, lb_data, sdr_addr}), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        mon_en = 1'b1;

        // 1: single 16px object, plain orientation
        set_obj(0, 100, 0, 0, 5, 5, 3, 0, 0, 0, 40);
        prepare(107, 0);
        check("t1_model_fetch", 64'(exp_fetch[0]), 64'h08002B8);
        check("t1_model_count", 64'(exp_wr.size()), 64'd15);
        start_line(107, 0);
        check("t1_busy", 64'(busy), 64'd1);
        wait_done("t1", 107);
        check("t1_fetch", 64'(first_fetch), 64'h08002B8);
        check("t1_first_wr", 64'(first_wr), 64'({10'd41, 12'h031}));
        check("t1_last_wr", 64'(last_wr), 64'({10'd55, 12'h03F}));
        check("t1_wr_count", 64'(wr_count), 64'd15);

        // 2: flipx + flipy
        set_obj(0, 100, 0, 0, 5, 5, 3, 0, 1, 1, 40);
        prepare(107, 0);
        check("t2_model_first", 64'(exp_wr[0]), 64'({10'd40, 12'h03F}));
        start_line(107, 0);
        wait_done("t2", 107);
        check("t2_fetch", 64'(first_fetch), 64'h08002C0);
        check("t2_first_wr", 64'(first_wr), 64'({10'd40, 12'h03F}));
        check("t2_last_wr", 64'(last_wr), 64'({10'd54, 12'h031}));
        check("t2_wr_count", 64'(wr_count), 64'd15);

        // 3: y wrap with 32px height, overlapping earlier object, irregular ce
        clear_objs();
        set_obj(3, 8, 0, 0, 0, 16'h0020, 2, 0, 0, 0, 108);
        set_obj(7, 500, 1, 0, 0, 16'h0100, 7'h55, 1, 0, 0, 100);
        prepare(10, 0);
        check("t3_model_fetch", 64'(exp_fetch[1]), 64'h08080B0);
        check("t3_model_count", 64'(exp_wr.size()), 64'd30);
        ce_rand = 1'b1;
        start_line(10, 0);
        wait_done("t3", 10);
        ce_rand = 1'b0;
        check("t3_last_wr", 64'(last_wr), 64'({10'd115, 12'hD5F}));
        check("t3_wr_count", 64'(wr_count), 64'd30);

        // 4: multi-column objects clipped at H_VISIBLE and wrapping past x=1023
        clear_objs();
        set_obj(0, 100, 0, 2, 0, 8, 1, 0, 0, 0, 310);
        set_obj(1, 100, 0, 1, 0, 8, 2, 0, 0, 0, 1020);
        prepare(107, 0);
        check("t4_model_count", 64'(exp_wr.size()), 64'd36);
        start_line(107, 0);
        wait_done("t4", 107);
        check("t4_fetch_count", 64'(fetch_count), 64'd6);
        check("t4_wr_count", 64'(wr_count), 64'd36);

        // 5: line_start arriving mid-DRAW restarts the scan
        clear_objs();
        set_obj(0, 100, 0, 3, 0, 16'h0040, 4, 0, 0, 0, 0);
        set_obj(5, 100, 0, 0, 0, 16'h0030, 6, 1, 1, 0, 200);
        prepare(107, 0);
        start_line(107, 0);
        n = 0;
        while (wr_count < 5 && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        check("t5_reached_draw", 64'(wr_count >= 5), 64'd1);
        vline = 9'd108; line_start = 1'b1;
        @(posedge clk); #1;
        line_start = 1'b0;
        check("t5_we_stop", 64'(lb_we), 64'd0);
        prepare(108, 0);
        wait_done("t5", 108);
        check("t5_wr_count", 64'(wr_count), 64'd135);

        // 6: object RAM busy at line start renders nothing
        prepare(107, 1);
        start_line(107, 1);
        wait_done("t6", 107);
        check("t6_done_latency", 64'((done_cyc - start_cyc) <= 2), 64'd1);
        check("t6_no_fetch", 64'(fetch_count), 64'd0);
        check("t6_no_write", 64'(wr_count), 64'd0);
        check("t6_busy_after", 64'(busy), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
